demux_scan_ctrl: RTL and testbench

- Upstream sequencer for the 8-way demux. Drives its select inputs a, b, c and its enable e.
- Steps through the enabled output channels in ascending order, holding each one for a programmable dwell time.
- Runs as a single sweep or continuously. Has a start/stop handshake and a per-sweep completion pulse.

---
 rtl/demux_scan_pkg.sv | 21 ++
 rtl/scan_next_sel.sv | 37 +++
 rtl/demux_scan_ctrl.sv | 137 +++++++++++++
 tb/tb_demux_scan_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_scan_pkg.sv
// ============================================================================
// Module      : demux_scan_pkg
// Description : Shared constants and state encoding for the demux scan block.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package demux_scan_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DWELL = 2'd1,
    S_GAP   = 2'd2
  } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/scan_next_sel.sv
// ============================================================================
// Module      : scan_next_sel
// Description : Priority search for the next enabled channel above the current
//               one, and for the lowest enabled channel (wrap/start target).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module scan_next_sel
  import demux_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [SEL_W-1:0]  cur_i,
  output logic [SEL_W-1:0]  next_o,
  output logic              found_o,
  output logic [SEL_W-1:0]  first_o
);

  // Descending walk so the last hit written is the lowest qualifying bit.
  always_comb begin
    next_o  = '0;
    found_o = 1'b0;
    first_o = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        first_o = SEL_W'(i);
        if (SEL_W'(i) > cur_i) begin
          next_o  = SEL_W'(i);
          found_o = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/demux_scan_ctrl.sv
// ============================================================================
// Module      : demux_scan_ctrl
// Description : Channel sequencer driving the 8-way demux selects and enable.
//               Define SCAN_BLANK_EN for one blank cycle per channel change.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module demux_scan_ctrl
  import demux_scan_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [NUM_CH-1:0]  chan_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic               a,
  output logic               b,
  output logic               c,
  output logic               e,
  output logic               busy,
  output logic               sweep_done
);

`ifdef SCAN_BLANK_EN
  localparam scan_state_t ADV_STATE = S_GAP;
`else
  localparam scan_state_t ADV_STATE = S_DWELL;
`endif

  scan_state_t        state_q, state_d;
  logic [SEL_W-1:0]   sel_q,   sel_d;
  logic [DWELL_W-1:0] cnt_q,   cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [NUM_CH-1:0]  mask_q,  mask_d;
  logic               mode_q,  mode_d;
  logic               done_q,  done_d;

  logic [NUM_CH-1:0]  w_mask;
  logic [SEL_W-1:0]   w_next;
  logic               w_found;
  logic [SEL_W-1:0]   w_first;
  logic               w_last;

  // While idle the search looks at the live mask to pick the start channel.
  assign w_mask = (state_q == S_IDLE) ? chan_mask : mask_q;
  assign w_last = (cnt_q == dwell_q - DWELL_W'(1));

  scan_next_sel u_next_sel (
    .mask_i  (w_mask),
    .cur_i   (sel_q),
    .next_o  (w_next),
    .found_o (w_found),
    .first_o (w_first)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    mask_d  = mask_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !stop && (|chan_mask)) begin
          state_d = S_DWELL;
          sel_d   = w_first;
          cnt_d   = '0;
          mask_d  = chan_mask;
          mode_d  = mode;
          dwell_d = (dwell == '0) ? DWELL_W'(1) : dwell;
        end
      end
      S_DWELL: begin
        if (stop) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (w_last) begin
          cnt_d = '0;
          if (w_found) begin
            sel_d   = w_next;
            state_d = ADV_STATE;
          end else if (mode_q) begin
            done_d  = 1'b1;
            sel_d   = w_first;
            state_d = ADV_STATE;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
`ifdef SCAN_BLANK_EN
      S_GAP: begin
        state_d = stop ? S_IDLE : S_DWELL;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      dwell_q <= '0;
      mask_q  <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  assign {a, b, c}  = sel_q;
  assign e          = (state_q == S_DWELL);
  assign busy       = (state_q != S_IDLE);
  assign sweep_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_demux_scan_ctrl.sv
// ============================================================================
// Module      : tb_demux_scan_ctrl
// Description : Randomized and directed bench for demux_scan_ctrl against a
//               channel-list reference model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_demux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] chan_mask = 8'h00;
  logic [7:0] dwell = 8'h00;
  logic       a, b, c, e, busy, sweep_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  demux_scan_ctrl #(.DWELL_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .chan_mask  (chan_mask),
    .dwell      (dwell),
    .a          (a),
    .b          (b),
    .c          (c),
    .e          (e),
    .busy       (busy),
    .sweep_done (sweep_done)
  );

  // Reference model: an ordered list of channels to visit plus a countdown.
  int m_list[$];
  int m_busy = 0, m_gap = 0, m_done = 0, m_chan = 0;
  int m_idx = 0, m_rem = 0, m_deff = 1, m_mode = 0;

  int cyc = 0;
  int e_cnt, e_first, e_last, done_cnt, eidle_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_update();
    if (!rst_n) begin
      m_busy = 0; m_gap = 0; m_done = 0; m_chan = 0;
      m_list.delete();
      return;
    end
    m_done = 0;
    if (m_busy != 0) begin
      if (stop) begin
        m_busy = 0;
        m_gap  = 0;
      end else if (m_gap != 0) begin
        m_gap = 0;
        m_rem = m_deff;
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_idx++;
          if (m_idx == m_list.size()) begin
            m_done = 1;
            if (m_mode != 0) m_idx = 0;
            else             m_busy = 0;
          end
          if (m_busy != 0) begin
            m_chan = m_list[m_idx];
            m_rem  = m_deff;
`ifdef SCAN_BLANK_EN
            m_gap  = 1;
`endif
          end
        end
      end
    end else if (start && !stop && chan_mask != 8'h00) begin
      m_list.delete();
      for (int i = 0; i < 8; i++)
        if (chan_mask[i]) m_list.push_back(i);
      m_idx  = 0;
      m_chan = m_list[0];
      m_deff = (dwell == 8'd0) ? 1 : int'(dwell);
      m_rem  = m_deff;
      m_mode = int'(mode);
      m_busy = 1;
      m_gap  = 0;
    end
  endtask

  task automatic clr_stats();
    e_cnt = 0; e_first = -1; e_last = -1; done_cnt = 0; eidle_cnt = 0;
  endtask

  // One clock: model advances on the edge, outputs compared mid-cycle.
  task automatic step();
    @(posedge clk);
    model_update();
    cyc++;
    @(negedge clk);
    check("abc",        32'({a, b, c}),    32'(m_chan));
    check("e",          32'(e),            32'((m_busy != 0) && (m_gap == 0)));
    check("busy",       32'(busy),         32'(m_busy));
    check("sweep_done", 32'(sweep_done),   32'(m_done));
    if (e) begin
      e_cnt++;
      if (e_first < 0) e_first = cyc;
      e_last = cyc;
    end
    if (busy && !e) eidle_cnt++;
    if (sweep_done) done_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic go(input logic [7:0] msk, input logic [7:0] dw, input logic md);
    chan_mask = msk; dwell = dw; mode = md; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  int found;

  initial begin
    clr_stats();
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
    run(1);

    // Reset in the middle of a sweep
    go(8'hFF, 8'd3, 1'b0);
    run(5);
    rst_n = 1'b0;
    run(2);
    check("rst_e",    32'(e),          32'd0);
    check("rst_busy", 32'(busy),       32'd0);
    check("rst_abc",  32'({a, b, c}),  32'd0);
    check("rst_done", 32'(sweep_done), 32'd0);
    rst_n = 1'b1;
    run(1);

    // Full single sweep
    clr_stats();
    go(8'hFF, 8'd2, 1'b0);
    run(30);
    check("full_ecnt", 32'(e_cnt), 32'd16);
`ifdef SCAN_BLANK_EN
    check("full_span", 32'(e_last - e_first + 1), 32'd23);
    check("full_gaps", 32'(eidle_cnt),            32'd7);
`else
    check("full_span", 32'(e_last - e_first + 1), 32'd16);
`endif
    check("full_done", 32'(done_cnt), 32'd1);
    check("full_idle", 32'(busy),     32'd0);

    // Sparse continuous
    clr_stats();
    go(8'b1010_0100, 8'd1, 1'b1);
    run(17);
`ifndef SCAN_BLANK_EN
    check("cont_nogap", 32'(eidle_cnt), 32'd0);
`endif
    check("cont_busy", 32'(busy), 32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("cont_stop", 32'(busy), 32'd0);

    // Abort during the second dwell cycle of channel 3
    clr_stats();
    go(8'hFF, 8'd4, 1'b0);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      if (e && {a, b, c} == 3'd3) found = 1;
      else step();
    end
    check("abort_reach", 32'(found), 32'd1);
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("abort_busy", 32'(busy),         32'd0);
    check("abort_e",    32'(e),            32'd0);
    check("abort_abc",  32'({a, b, c}),    32'd3);
    check("abort_done", 32'(done_cnt),     32'd0);
    go(8'hFF, 8'd1, 1'b0);
    check("restart_abc", 32'({a, b, c}), 32'd0);
    run(20);

    // Corner inputs
    go(8'h00, 8'd2, 1'b0);
    check("mask0_busy", 32'(busy), 32'd0);
    clr_stats();
    go(8'h01, 8'd0, 1'b0);
    run(4);
    check("dwell0_ecnt", 32'(e_cnt), 32'd1);
    stop = 1'b1;
    go(8'hFF, 8'd2, 1'b0);
    stop = 1'b0;
    check("startstop_busy", 32'(busy), 32'd0);
    clr_stats();
    go(8'h0F, 8'd2, 1'b0);
    run(2);
    go(8'hF0, 8'd5, 1'b1);
    run(12);
    check("startbusy_ecnt", 32'(e_cnt), 32'd8);
    check("startbusy_done", 32'(done_cnt), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      start     = ($urandom_range(0, 3) == 0);
      stop      = ($urandom_range(0, 39) == 0);
      mode      = 1'($urandom_range(0, 1));
      chan_mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      dwell     = 8'($urandom_range(0, 4));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
